spi_tx_shifter: RTL and testbench

//  Serial transmit stage that consumes the clk_in/DIV timing of the clock divider internally.

---
 rtl/spi_tx_shifter_if.sv | 20 ++
 rtl/spi_tx_shifter.sv | 123 ++++++++++++
 tb/tb_spi_tx_shifter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_shifter_if.sv
// rtl/spi_tx_shifter_if.sv - parallel word handshake into the SPI transmit shifter
interface spi_tx_shifter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - SPI mode-0 master transmit shifter, MSB first
// sclk is a registered data output paced by a half-period counter on clk_in.
module spi_tx_shifter #(
   parameter int DIV   = 32,
   parameter int WIDTH = 8
) (
   input  logic            clk_in,
   input  logic            rst,
   spi_tx_shifter_if.slave tx,
   output logic            sclk,
   output logic            mosi,
   output logic            cs_n,
   output logic            busy,
   output logic            done
);
   localparam int HALF = DIV / 2;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int BW   = $clog2(WIDTH + 1);
   localparam logic [HW-1:0] TC       = HW'(HALF - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state_q, state_d;
   logic [HW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] sreg_q, sreg_d, sreg_sh;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sreg_d  = sreg_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      done_d  = 1'b0;
      sreg_sh = sreg_q << 1;
      case (state_q)
         IDLE: begin
            if (tx.tx_valid && ready_q) begin
               state_d = SHIFT;
               sreg_d  = tx.tx_data;
               mosi_d  = tx.tx_data[WIDTH-1];
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         SHIFT: begin
            if (cnt_q == TC) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  // The last bit stays on mosi through FINISH.
                  if (bit_q == LAST_BIT) begin
                     state_d = FINISH;
                  end else begin
                     bit_d  = bit_q + BW'(1);
                     sreg_d = sreg_sh;
                     mosi_d = sreg_sh[WIDTH-1];
                  end
               end
            end else begin
               cnt_d = cnt_q + HW'(1);
            end
         end
         FINISH: begin
            if (cnt_q == TC) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = IDLE;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered so ready stays low until the first edge after reset release.
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sreg_q  <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sreg_q  <= sreg_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign tx.tx_ready = ready_q;
   assign sclk        = sclk_q;
   assign mosi        = mosi_q;
   assign cs_n        = cs_n_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_spi_tx_shifter.sv
// tb/tb_spi_tx_shifter.sv - bench for spi_tx_shifter at DIV=4/WIDTH=8 and DIV=2/WIDTH=1
module tb_spi_tx_shifter;
   logic clk_in = 1'b0;
   logic rst_a  = 1'b1;
   logic rst_b  = 1'b1;
   logic sclk_a, mosi_a, cs_n_a, busy_a, done_a;
   logic sclk_b, mosi_b, cs_n_b, busy_b, done_b;

   spi_tx_shifter_if #(.WIDTH(8)) ifa ();
   spi_tx_shifter_if #(.WIDTH(1)) ifb ();

   spi_tx_shifter #(.DIV(4), .WIDTH(8)) dut_a (
      .clk_in(clk_in), .rst(rst_a), .tx(ifa.slave),
      .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a)
   );

   spi_tx_shifter #(.DIV(2), .WIDTH(1)) dut_b (
      .clk_in(clk_in), .rst(rst_b), .tx(ifb.slave),
      .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0;
   int fails = 0;
   int ncyc  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, ncyc);
      end
   endtask

   always @(posedge clk_in) ncyc++;

   // Frame model: p counts cycles since the first SHIFT cycle, -1 when idle.
   int         p [2]         = '{-1, -1};
   logic       ready_m [2]   = '{1'b0, 1'b0};
   logic       done_m [2]    = '{1'b0, 1'b0};
   logic       idle_mosi [2] = '{1'b0, 1'b0};
   logic [7:0] word_m [2]    = '{8'h00, 8'h00};

   task automatic model_reset(input int i);
      p[i] = -1;
      ready_m[i] = 1'b0;
      done_m[i] = 1'b0;
      idle_mosi[i] = 1'b0;
   endtask

   task automatic model_step(input int i, input int d, input int w, input logic v, input logic [7:0] data);
      done_m[i] = 1'b0;
      if (p[i] >= 0) begin
         p[i]++;
         if (p[i] == w * d + d / 2) begin
            p[i] = -1;
            done_m[i] = 1'b1;
            ready_m[i] = 1'b1;
            idle_mosi[i] = word_m[i][0];
         end
      end else if (ready_m[i] && v) begin
         p[i] = 0;
         word_m[i] = data;
         ready_m[i] = 1'b0;
      end else begin
         ready_m[i] = 1'b1;
      end
   endtask

   function automatic logic [5:0] exp_vec(input int i, input int d, input int w);
      logic s, m, c, b;
      if (p[i] < 0) begin
         s = 1'b0; m = idle_mosi[i]; c = 1'b1; b = 1'b0;
      end else if (p[i] < w * d) begin
         s = ((p[i] % d) >= d / 2);
         m = word_m[i][w - 1 - p[i] / d];
         c = 1'b0; b = 1'b1;
      end else begin
         s = 1'b0; m = word_m[i][0]; c = 1'b0; b = 1'b1;
      end
      return {s, m, c, b, done_m[i], ready_m[i]};
   endfunction

   always @(posedge clk_in or negedge rst_a)
      if (!rst_a) model_reset(0);
      else model_step(0, 4, 8, ifa.tx_valid, ifa.tx_data);

   always @(posedge clk_in or negedge rst_b)
      if (!rst_b) model_reset(1);
      else model_step(1, 2, 1, ifb.tx_valid, {7'b0, ifb.tx_data});

   int acc_a = 0, csl_a = 0, acc_b = 0, shi_b = 0;

   always @(negedge clk_in) begin
      chk("cycle_a", {26'b0, sclk_a, mosi_a, cs_n_a, busy_a, done_a, ifa.tx_ready}, {26'b0, exp_vec(0, 4, 8)});
      chk("cycle_b", {26'b0, sclk_b, mosi_b, cs_n_b, busy_b, done_b, ifb.tx_ready}, {26'b0, exp_vec(1, 2, 1)});
      if (!cs_n_a) csl_a++;
      if (done_a) begin
         chk("done_latency_a", ncyc - acc_a, 35);
         chk("cs_low_cycles_a", csl_a, 34);
      end
      if (ifa.tx_valid && ifa.tx_ready) begin acc_a = ncyc; csl_a = 0; end
      if (sclk_b) shi_b++;
      if (done_b) begin
         chk("done_latency_b", ncyc - acc_b, 4);
         chk("sclk_high_b", shi_b, 1);
      end
      if (ifb.tx_valid && ifb.tx_ready) begin acc_b = ncyc; shi_b = 0; end
   end

   // Slave-side decoders: sample mosi on sclk rise, keep only complete frames.
   logic [7:0] sh_a = '0;
   int         nb_a = 0;
   logic [7:0] words_a[$];
   logic       sh_b = 1'b0;
   int         nb_b = 0;
   logic       words_b[$];

   always @(posedge sclk_a or posedge cs_n_a)
      if (cs_n_a) begin
         if (nb_a == 8) words_a.push_back(sh_a);
         nb_a = 0;
      end else begin
         sh_a = {sh_a[6:0], mosi_a};
         nb_a++;
      end

   always @(posedge sclk_b or posedge cs_n_b)
      if (cs_n_b) begin
         if (nb_b == 1) words_b.push_back(sh_b);
         nb_b = 0;
      end else begin
         sh_b = mosi_b;
         nb_b++;
      end

   task automatic wait_acc(input int i, output int t);
      logic rdy;
      t = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_in);
         rdy = (i == 0) ? ifa.tx_ready : ifb.tx_ready;
         if (rdy) begin
            t = ncyc;
            @(posedge clk_in);
            #1;
            return;
         end
      end
      chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_done(input int i);
      logic d;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_in);
         d = (i == 0) ? done_a : done_b;
         if (d) return;
      end
      chk("done_timeout", 0, 1);
   endtask

   int t1, t2;
   logic [7:0] exp_a [5] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h96};

   initial begin
      ifa.tx_valid = 1'b1;
      ifa.tx_data  = 8'hA5;
      ifb.tx_valid = 1'b0;
      ifb.tx_data  = 1'b0;
      #1 rst_a = 1'b0; rst_b = 1'b0;

      // Reset held with a pending request.
      repeat (3) @(negedge clk_in);
      chk("reset_outputs_a", {26'b0, sclk_a, mosi_a, cs_n_a, busy_a, done_a, ifa.tx_ready}, 32'h08);
      chk("reset_outputs_b", {26'b0, sclk_b, mosi_b, cs_n_b, busy_b, done_b, ifb.tx_ready}, 32'h08);
      @(posedge clk_in); #1;
      ifa.tx_valid = 1'b0;
      #2 rst_a = 1'b1; rst_b = 1'b1;
      #1 chk("ready_before_edge", {31'b0, ifa.tx_ready}, 0);
      @(posedge clk_in); #1;
      chk("ready_after_release", {31'b0, ifa.tx_ready}, 1);

      // Single word 0xA5.
      ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
      wait_acc(0, t1);
      ifa.tx_valid = 1'b0;
      wait_done(0);

      // Back-to-back 0x00 then 0xFF with tx_valid held.
      @(posedge clk_in); #1;
      ifa.tx_data = 8'h00; ifa.tx_valid = 1'b1;
      wait_acc(0, t1);
      ifa.tx_data = 8'hFF;
      wait_acc(0, t2);
      ifa.tx_valid = 1'b0;
      chk("back_to_back_gap", t2 - t1, 35);
      wait_done(0);

      // Request and data change while busy are ignored.
      @(posedge clk_in); #1;
      ifa.tx_data = 8'h3C; ifa.tx_valid = 1'b1;
      wait_acc(0, t1);
      ifa.tx_valid = 1'b0;
      repeat (6) @(posedge clk_in);
      #1 ifa.tx_data = 8'hC3; ifa.tx_valid = 1'b1;
      @(posedge clk_in); #1 ifa.tx_valid = 1'b0;
      wait_done(0);
      repeat (4) @(negedge clk_in);
      chk("no_queued_frame", {31'b0, busy_a}, 0);

      // Asynchronous abort during bit 3, then a clean frame.
      @(posedge clk_in); #1;
      ifa.tx_data = 8'h5A; ifa.tx_valid = 1'b1;
      wait_acc(0, t1);
      ifa.tx_valid = 1'b0;
      repeat (14) @(posedge clk_in);
      #3 rst_a = 1'b0;
      #1 chk("abort_outputs", {26'b0, sclk_a, mosi_a, cs_n_a, busy_a, done_a, ifa.tx_ready}, 32'h08);
      @(posedge clk_in); #2 rst_a = 1'b1;
      @(posedge clk_in); #1;
      ifa.tx_data = 8'h96; ifa.tx_valid = 1'b1;
      wait_acc(0, t1);
      ifa.tx_valid = 1'b0;
      wait_done(0);

      // DIV=2, WIDTH=1.
      @(posedge clk_in); #1;
      ifb.tx_data = 1'b1; ifb.tx_valid = 1'b1;
      wait_acc(1, t1);
      ifb.tx_valid = 1'b0;
      wait_done(1);

      repeat (3) @(negedge clk_in);
      chk("words_a_count", words_a.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < words_a.size()) chk("word_a", {24'b0, words_a[k]}, {24'b0, exp_a[k]});
      chk("words_b_count", words_b.size(), 1);
      if (words_b.size() > 0) chk("word_b", {31'b0, words_b[0]}, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
